// File: rtl/frame_sync_gen.sv
// frame_sync_gen: hunt/confirm/lock/flywheel frame synchroniser for a
// valid-qualified symbol stream. Tracks a multi-symbol sync word, keeps a
// frame-position counter and emits lock status plus a per-frame sync pulse.
// Optional macro SYNC_ERR_TOL_EN: check-beat header matching in CHECK, LOCK
// and HOLD tolerates up to MAX_BIT_ERR bit errors (acquisition stays exact).
module frame_sync_gen #(
   parameter int DATA_W = 8,
   parameter int HEAD_BYTES = 2,
   parameter logic [DATA_W*HEAD_BYTES-1:0] HEAD_PATTERN = 16'h471D,
   parameter int FRAME_LEN = 10,
   parameter int CONFIRM_CNT = 3,
   parameter int MISS_ALLOW = 3
`ifdef SYNC_ERR_TOL_EN
   ,
   parameter int MAX_BIT_ERR = 1
`endif
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_W-1:0]            din,
   input  logic                         din_vld,
   output logic                         locked,
   output logic                         sync_pulse,
   output logic                         hdr_ok,
   output logic [$clog2(FRAME_LEN)-1:0] frame_pos,
   output logic [3:0]                   state
);

   localparam int WIN_W  = DATA_W * HEAD_BYTES;
   localparam int POS_W  = $clog2(FRAME_LEN);
   localparam int FILL_W = (HEAD_BYTES > 1) ? $clog2(HEAD_BYTES) : 1;
   localparam int CONF_W = $clog2(CONFIRM_CNT + 1);
   localparam int MISS_W = (MISS_ALLOW > 0) ? $clog2(MISS_ALLOW + 1) : 1;
   localparam int HIST_W = (HEAD_BYTES > 1) ? (HEAD_BYTES - 1) * DATA_W : DATA_W;

   typedef enum logic [3:0] {
      S_SEARCH = 4'b0001,
      S_CHECK  = 4'b0010,
      S_LOCK   = 4'b0100,
      S_HOLD   = 4'b1000
   } state_t;

   state_t             state_q, state_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [CONF_W-1:0]  conf_q, conf_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [HIST_W-1:0]  hist_q, hist_d;
   logic               locked_q, locked_d;
   logic               sync_q, sync_d;
   logic               hdr_ok_q, hdr_ok_d;

   logic [WIN_W-1:0]   window;
   logic               fill_full;
   logic               exact_hit;
   logic               chk_hit;
   logic               check_beat;

`ifdef SYNC_ERR_TOL_EN
   // Number of set bits, used as the Hamming distance of window ^ pattern.
   function automatic int unsigned bit_errs(input logic [WIN_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < WIN_W; i++) n = n + 32'(v[i]);
      return n;
   endfunction
`endif

   generate
      if (HEAD_BYTES > 1) begin : g_hist
         // Window is the stored older symbols followed by the current one.
         always_comb window = {hist_q, din};
      end else begin : g_nohist
         // Single-symbol sync word: the window is just the current symbol.
         always_comb window = din;
      end
   endgenerate

   // Header match qualifiers and the frame-boundary check beat.
   always_comb begin
      fill_full  = (fill_q == FILL_W'(HEAD_BYTES - 1));
      exact_hit  = fill_full && (window == HEAD_PATTERN);
`ifdef SYNC_ERR_TOL_EN
      chk_hit    = fill_full && (bit_errs(window ^ HEAD_PATTERN) <= $unsigned(MAX_BIT_ERR));
`else
      chk_hit    = exact_hit;
`endif
      check_beat = (pos_q == POS_W'(FRAME_LEN - 1));
   end

   // Next-state logic: everything advances only on valid beats.
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      conf_d   = conf_q;
      miss_d   = miss_q;
      fill_d   = fill_q;
      hist_d   = hist_q;
      sync_d   = 1'b0;
      hdr_ok_d = 1'b0;
      if (din_vld) begin
         hist_d = window[HIST_W-1:0];
         if (!fill_full) fill_d = fill_q + 1'b1;
         pos_d = check_beat ? '0 : pos_q + 1'b1;
         case (state_q)
            S_SEARCH: begin
               pos_d = '0;
               if (exact_hit) begin
                  state_d = S_CHECK;
                  conf_d  = '0;
               end
            end
            S_CHECK: begin
               if (check_beat) begin
                  if (chk_hit) begin
                     if (conf_q == CONF_W'(CONFIRM_CNT - 1)) begin
                        state_d  = S_LOCK;
                        conf_d   = '0;
                        sync_d   = 1'b1;
                        hdr_ok_d = 1'b1;
                     end else begin
                        conf_d = conf_q + 1'b1;
                     end
                  end else begin
                     state_d = S_SEARCH;
                  end
               end
            end
            S_LOCK: begin
               if (check_beat) begin
                  sync_d   = 1'b1;
                  hdr_ok_d = chk_hit;
                  if (!chk_hit) begin
                     if (MISS_ALLOW == 0) begin
                        state_d = S_SEARCH;
                     end else begin
                        state_d = S_HOLD;
                        miss_d  = MISS_W'(1);
                     end
                  end
               end
            end
            S_HOLD: begin
               if (check_beat) begin
                  sync_d   = 1'b1;
                  hdr_ok_d = chk_hit;
                  if (chk_hit) begin
                     state_d = S_LOCK;
                     miss_d  = '0;
                  end else if (miss_q == MISS_W'(MISS_ALLOW)) begin
                     state_d = S_SEARCH;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = S_SEARCH;
               pos_d   = '0;
            end
         endcase
      end
      locked_d = (state_d == S_LOCK) || (state_d == S_HOLD);
   end

   // State, counters, history and registered outputs; async reset clears all.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_SEARCH;
         pos_q    <= '0;
         conf_q   <= '0;
         miss_q   <= '0;
         fill_q   <= '0;
         hist_q   <= '0;
         locked_q <= 1'b0;
         sync_q   <= 1'b0;
         hdr_ok_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         conf_q   <= conf_d;
         miss_q   <= miss_d;
         fill_q   <= fill_d;
         hist_q   <= hist_d;
         locked_q <= locked_d;
         sync_q   <= sync_d;
         hdr_ok_q <= hdr_ok_d;
      end
   end

   assign locked     = locked_q;
   assign sync_pulse = sync_q;
   assign hdr_ok     = hdr_ok_q;
   assign frame_pos  = pos_q;
   assign state      = state_q;

endmodule

// File: tb/tb_frame_sync_gen.sv
// tb_frame_sync_gen: randomized-payload bench for frame_sync_gen with a
// behavioural reference model based on valid-beat indices and a symbol queue.
module tb_frame_sync_gen;

   localparam int HB = 2;
   localparam int FL = 10;
   localparam int CC = 3;
   localparam int MA = 3;
   localparam logic [15:0] PAT = 16'h471D;
`ifdef SYNC_ERR_TOL_EN
   localparam int MAXERR = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       din_vld;
   logic       locked, sync_pulse, hdr_ok;
   logic [3:0] frame_pos;
   logic [3:0] state;

   always #5 clk = ~clk;

   frame_sync_gen dut (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
      .locked(locked), .sync_pulse(sync_pulse), .hdr_ok(hdr_ok),
      .frame_pos(frame_pos), .state(state)
   );

   int n_checks = 0;
   int n_pass = 0;

   // Reference model: beat indices instead of counters.
   logic [7:0] hist[$];
   int vidx, anchor, mode, hits, misses, m_pos;
   logic m_sync, m_hdr;

   task automatic m_reset();
      hist.delete();
      vidx = 0; anchor = 0; mode = 0; hits = 0; misses = 0; m_pos = 0;
      m_sync = 1'b0; m_hdr = 1'b0;
   endtask

   task automatic m_beat(input logic [7:0] d, input logic v);
      logic [15:0] w;
      bit filled, ex, tl, chk;
      m_sync = 1'b0;
      m_hdr = 1'b0;
      if (!v) return;
      hist.push_back(d);
      if (hist.size() > HB) void'(hist.pop_front());
      filled = (hist.size() == HB);
      w = '0;
      foreach (hist[k]) w = (w << 8) | 16'(hist[k]);
      ex = filled && (w == PAT);
`ifdef SYNC_ERR_TOL_EN
      tl = filled && ($countones(w ^ PAT) <= MAXERR);
`else
      tl = ex;
`endif
      vidx++;
      chk = (mode != 0) && (vidx - anchor == FL);
      if (chk) anchor = vidx;
      case (mode)
         0: if (ex) begin mode = 1; anchor = vidx; hits = 1; end
         1: if (chk) begin
               if (tl) begin
                  hits++;
                  if (hits == CC + 1) begin mode = 2; m_sync = 1'b1; m_hdr = 1'b1; end
               end else mode = 0;
            end
         2: if (chk) begin
               m_sync = 1'b1; m_hdr = tl;
               if (!tl) begin misses = 1; mode = (MA == 0) ? 0 : 3; end
            end
         default: if (chk) begin
               m_sync = 1'b1; m_hdr = tl;
               if (tl) begin mode = 2; misses = 0; end
               else if (misses == MA) begin mode = 0; misses = 0; end
               else misses++;
            end
      endcase
      m_pos = (mode == 0) ? 0 : vidx - anchor;
   endtask

   function automatic logic [10:0] exp_vec();
      return {1'(mode >= 2), m_sync, m_hdr, 4'(m_pos), 4'(1 << mode)};
   endfunction

   function automatic logic [7:0] rnd_pay();
      logic [7:0] b;
      do b = 8'($urandom); while ($countones(b ^ 8'h47) <= 1);
      return b;
   endfunction

   function automatic logic [7:0] fbyte(input int k, input logic [7:0] h1);
      if (k == 0) return 8'h47;
      if (k == 1) return h1;
      return rnd_pay();
   endfunction

   task automatic step(input logic [7:0] d, input logic v);
      @(negedge clk);
      din = d; din_vld = v;
      m_beat(d, v);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; din_vld = 1'b0; din = '0;
      @(negedge clk);
      rst = 1'b0;
      m_reset();
   endtask

   task automatic lock_up();
      for (int f = 0; f < 4; f++)
         for (int k = 0; k < FL; k++) step(fbyte(k, 8'h1D), 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1; din_vld = 1'b1; din = 8'h47;
      m_reset();
      repeat (2) @(posedge clk);
      din = 8'h1D;
      @(posedge clk); #1;
      n_checks++;
      if ({locked, sync_pulse, hdr_ok, frame_pos, state} !== {3'b000, 4'd0, 4'b0001})
         $display("FAIL reset_hold: got %b want %b", {locked, sync_pulse, hdr_ok, frame_pos, state}, {3'b000, 4'd0, 4'b0001});
      else n_pass++;
      @(negedge clk);
      din_vld = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({locked, sync_pulse, hdr_ok, frame_pos, state} !== {3'b000, 4'd0, 4'b0001})
         $display("FAIL reset_release: got %b want %b", {locked, sync_pulse, hdr_ok, frame_pos, state}, {3'b000, 4'd0, 4'b0001});
      else n_pass++;
   endtask

   task automatic test_acquire();
      do_reset();
      for (int f = 0; f < 5; f++)
         for (int k = 0; k < FL; k++) begin
            step(fbyte(k, 8'h1D), 1'b1);
            n_checks++;
            if ({locked, sync_pulse, hdr_ok, frame_pos, state} !== exp_vec())
               $display("FAIL acq_beat f%0d k%0d: got %b want %b", f, k, {locked, sync_pulse, hdr_ok, frame_pos, state}, exp_vec());
            else n_pass++;
            if (f == 3 && k == 0) begin
               n_checks++;
               if (locked !== 1'b0) $display("FAIL acq_early_lock: got %b want 0", locked);
               else n_pass++;
            end
            if (f == 3 && k == 1) begin
               n_checks++;
               if ({locked, sync_pulse, hdr_ok, state} !== 7'b1110100)
                  $display("FAIL acq_lock: got %b want 1110100", {locked, sync_pulse, hdr_ok, state});
               else n_pass++;
            end
            if (f == 4) begin
               n_checks++;
               if (frame_pos !== ((k == 0) ? 4'd9 : (k == 1) ? 4'd0 : 4'(k - 1)))
                  $display("FAIL acq_pos k%0d: got %0d", k, frame_pos);
               else n_pass++;
            end
         end
   endtask

   task automatic test_flywheel(input bit recover);
      do_reset();
      lock_up();
      for (int f = 0; f < 4; f++)
         for (int k = 0; k < FL; k++) begin
            step(fbyte(k, (recover && f == 3) ? 8'h1D : 8'h00), 1'b1);
            n_checks++;
            if ({locked, sync_pulse, hdr_ok, frame_pos, state} !== exp_vec())
               $display("FAIL fly_beat r%0d f%0d k%0d: got %b want %b", recover, f, k, {locked, sync_pulse, hdr_ok, frame_pos, state}, exp_vec());
            else n_pass++;
            if (k == 1 && f == 2) begin
               n_checks++;
               if ({locked, sync_pulse, hdr_ok, state} !== 7'b1101000)
                  $display("FAIL fly_hold: got %b want 1101000", {locked, sync_pulse, hdr_ok, state});
               else n_pass++;
            end
            if (k == 1 && f == 3) begin
               n_checks++;
               if ({locked, state} !== (recover ? 5'b10100 : 5'b00001))
                  $display("FAIL fly_end r%0d: got %b want %b", recover, {locked, state}, recover ? 5'b10100 : 5'b00001);
               else n_pass++;
            end
         end
   endtask

   task automatic test_false_acq();
      logic [7:0] seq[$];
      do_reset();
      seq = {rnd_pay(), rnd_pay(), rnd_pay(), 8'h47, 8'h1D};
      repeat (12) seq.push_back(rnd_pay());
      foreach (seq[i]) begin
         step(seq[i], 1'b1);
         n_checks++;
         if ({locked, sync_pulse, hdr_ok, frame_pos, state} !== exp_vec())
            $display("FAIL false_beat i%0d: got %b want %b", i, {locked, sync_pulse, hdr_ok, frame_pos, state}, exp_vec());
         else n_pass++;
         if (i == 4 || i == 14) begin
            n_checks++;
            if ({sync_pulse, state} !== ((i == 4) ? 5'b00010 : 5'b00001))
               $display("FAIL false_state i%0d: got %b", i, {sync_pulse, state});
            else n_pass++;
         end
      end
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < FL; k++) begin
            step(fbyte(k, (f == 1) ? 8'h00 : 8'h1D), 1'b1);
            n_checks++;
            if ({locked, sync_pulse, hdr_ok, frame_pos, state} !== exp_vec())
               $display("FAIL false2_beat f%0d k%0d: got %b want %b", f, k, {locked, sync_pulse, hdr_ok, frame_pos, state}, exp_vec());
            else n_pass++;
         end
      n_checks++;
      if (state !== 4'b0001) $display("FAIL false2_drop: got %b want 0001", state);
      else n_pass++;
   endtask

   task automatic test_gaps();
      do_reset();
      for (int f = 0; f < 4; f++)
         for (int k = 0; k < FL; k++)
            for (int g = 0; g < 2; g++) begin
               step((g == 0) ? fbyte(k, 8'h1D) : 8'(k), (g == 0));
               n_checks++;
               if ({locked, sync_pulse, hdr_ok, frame_pos, state} !== exp_vec())
                  $display("FAIL gap_beat f%0d k%0d g%0d: got %b want %b", f, k, g, {locked, sync_pulse, hdr_ok, frame_pos, state}, exp_vec());
               else n_pass++;
               if (f == 3 && k == 1) begin
                  n_checks++;
                  if ({locked, sync_pulse, state} !== ((g == 0) ? 6'b110100 : 6'b100100))
                     $display("FAIL gap_lock g%0d: got %b", g, {locked, sync_pulse, state});
                  else n_pass++;
               end
            end
   endtask

   task automatic test_async_reset();
      do_reset();
      lock_up();
      step(rnd_pay(), 1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({locked, sync_pulse, frame_pos, state} !== {2'b00, 4'd0, 4'b0001})
         $display("FAIL async_rst: got %b want %b", {locked, sync_pulse, frame_pos, state}, {2'b00, 4'd0, 4'b0001});
      else n_pass++;
      din_vld = 1'b0;
      #1 rst = 1'b0;
      m_reset();
      for (int f = 0; f < 4; f++)
         for (int k = 0; k < FL; k++) begin
            step(fbyte(k, 8'h1D), 1'b1);
            n_checks++;
            if ({locked, sync_pulse, hdr_ok, frame_pos, state} !== exp_vec())
               $display("FAIL relock_beat f%0d k%0d: got %b want %b", f, k, {locked, sync_pulse, hdr_ok, frame_pos, state}, exp_vec());
            else n_pass++;
            if (f == 3 && k < 2) begin
               n_checks++;
               if (locked !== (k == 1)) $display("FAIL relock k%0d: got %b", k, locked);
               else n_pass++;
            end
         end
   endtask

   task automatic test_tolerance();
      do_reset();
      lock_up();
      for (int k = 0; k < FL; k++) begin
         step(fbyte(k, 8'h1C), 1'b1);
         n_checks++;
         if ({locked, sync_pulse, hdr_ok, frame_pos, state} !== exp_vec())
            $display("FAIL tol_beat k%0d: got %b want %b", k, {locked, sync_pulse, hdr_ok, frame_pos, state}, exp_vec());
         else n_pass++;
         if (k == 1) begin
            n_checks++;
`ifdef SYNC_ERR_TOL_EN
            if ({sync_pulse, hdr_ok, state} !== 6'b110100)
               $display("FAIL tol_locked: got %b want 110100", {sync_pulse, hdr_ok, state});
`else
            if ({sync_pulse, hdr_ok, state} !== 6'b101000)
               $display("FAIL tol_locked: got %b want 101000", {sync_pulse, hdr_ok, state});
`endif
            else n_pass++;
         end
      end
      do_reset();
      step(8'h47, 1'b1);
      step(8'h1C, 1'b1);
      step(rnd_pay(), 1'b1);
      n_checks++;
      if (state !== 4'b0001) $display("FAIL tol_search: got %b want 0001", state);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0] h1;
      int r;
      do_reset();
      for (int f = 0; f < 30; f++) begin
         r = int'($urandom_range(0, 3));
         h1 = (r < 2) ? 8'h1D : (r == 2) ? 8'h1C : 8'h00;
         for (int k = 0; k < FL; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               step(8'($urandom), 1'b0);
               n_checks++;
               if ({locked, sync_pulse, hdr_ok, frame_pos, state} !== exp_vec())
                  $display("FAIL rnd_gap f%0d k%0d: got %b want %b", f, k, {locked, sync_pulse, hdr_ok, frame_pos, state}, exp_vec());
               else n_pass++;
            end
            step(fbyte(k, h1), 1'b1);
            n_checks++;
            if ({locked, sync_pulse, hdr_ok, frame_pos, state} !== exp_vec())
               $display("FAIL rnd_beat f%0d k%0d: got %b want %b", f, k, {locked, sync_pulse, hdr_ok, frame_pos, state}, exp_vec());
            else n_pass++;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      din_vld = 1'b0;
      din = '0;
      test_reset();
      test_acquire();
      test_flywheel(1'b0);
      test_flywheel(1'b1);
      test_false_acq();
      test_gaps();
      test_async_reset();
      test_tolerance();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/frame_sync_gen.md
Name: frame_sync_gen

Overview:
- Parametrised frame synchroniser for a symbol stream: multi-symbol sync word, configurable frame length, acquisition and flywheel thresholds, valid-qualified input.
- Four-state hunt/confirm/lock/flywheel machine drives a frame-position counter and outputs lock status and a per-frame sync pulse to downstream deframing logic.

Parameters:
- DATA_W, 8, symbol width in bits.
- HEAD_BYTES, 2, sync word length in symbols; must be ≥1.
- HEAD_PATTERN, 16'h471D, sync word, DATA_W*HEAD_BYTES bits; first-received symbol in the MSBs.
- FRAME_LEN, 10, valid beats per frame including header; must be >HEAD_BYTES.
- CONFIRM_CNT, 3, consecutive headers at the expected position, after the first, needed to lock; must be ≥1.
- MISS_ALLOW, 3, consecutive missed headers tolerated while locked; may be 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  DATA_W  input symbol.
- din_vld  in  1  din valid this cycle.
- locked  out  1  high in LOCK or HOLD.
- sync_pulse  out  1  one-cycle pulse per frame boundary while locked.
- hdr_ok  out  1  header-match result of the check beat that raised sync_pulse.
- frame_pos  out  $clog2(FRAME_LEN)  beat index since last header end.
- state  out  4  one-hot state: SEARCH=0001, CHECK=0010, LOCK=0100, HOLD=1000.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. Reset gives state=SEARCH, frame_pos=0, conf/miss counters=0, history=0, fill counter=0, locked=0, sync_pulse=0, hdr_ok=0. Assertion mid-operation clears everything immediately, without waiting for clk.
- All state, counters and history advance only on beats with din_vld=1. While din_vld=0, everything holds and sync_pulse=0.
- Window = {last HEAD_BYTES-1 valid symbols, din}.
- head_hit = (window == HEAD_PATTERN) AND din_vld AND fill counter has reached HEAD_BYTES-1. The fill counter saturates.
- Check beat: a valid beat with frame_pos==FRAME_LEN-1. On a check beat frame_pos wraps to 0; otherwise it increments in CHECK, LOCK and HOLD. frame_pos is held at 0 in SEARCH.
- SEARCH: head_hit -> CHECK, frame_pos=0, conf=0.
- CHECK, on a check beat:
  - hit and conf==CONFIRM_CNT-1 -> LOCK, conf=0.
  - hit otherwise -> conf+1.
  - miss -> SEARCH.
  - A header ending FRAME_LEN valid beats after the previous one is therefore expected; lock needs CONFIRM_CNT+1 headers in total.
- LOCK, on a check beat:
  - hit -> stay.
  - miss with MISS_ALLOW==0 -> SEARCH.
  - miss otherwise -> HOLD, miss_cnt=1.
- HOLD, on a check beat:
  - hit -> LOCK, miss_cnt=0.
  - miss with miss_cnt==MISS_ALLOW -> SEARCH, miss_cnt=0.
  - miss otherwise -> miss_cnt+1.
- Non-check beats never change state.
- A miss that drops to SEARCH does not also evaluate SEARCH acquisition on that beat.
- Outputs are registered.
  - sync_pulse is high for the cycle after every check beat taken in LOCK or HOLD, and after the check beat causing CHECK->LOCK.
  - hdr_ok is that beat's hit result, valid only with sync_pulse, 0 otherwise.
  - locked and state reflect the registered state.
- Counters are sized so they never wrap below their thresholds.

Optional Feature:
- SYNC_ERR_TOL_EN defined:
  - Adds parameter MAX_BIT_ERR (default 1).
  - Check-beat matching in CHECK, LOCK and HOLD accepts a window whose Hamming distance to HEAD_PATTERN is ≤MAX_BIT_ERR.
  - SEARCH acquisition remains exact match.
- Not defined: exact match everywhere; no popcount logic is synthesised.

Test Plan:
- Continuous din_vld, default parameters, four clean frames each starting 47,1D → locked rises one cycle after the 4th header's 1D beat, with sync_pulse=1, hdr_ok=1, state=0100; frame_pos then counts 0..9 and wraps.
- Missed-header flywheel:
  - Locked, headers corrupted in 3 consecutive frames → state=1000, locked stays 1, sync_pulse every 10 beats with hdr_ok=0.
  - A 4th consecutive corruption → state=0001, locked=0.
  - Alternatively, a clean header after 3 misses → state=0100.
- False acquisition: in SEARCH, payload bytes 47,1D → state=0010; next header absent 10 beats later → state=0001 with no sync_pulse. The same pattern with the 2nd real header corrupted → state=0001.
- Valid gaps: din_vld toggled 1,0,1,0 across four clean frames → same lock after 40 valid beats; frame_pos and state frozen on gap cycles.
- Async reset: rst pulsed between clock edges while in LOCK → locked, state=0001, frame_pos=0 before the next edge; relock needs four fresh headers.
- With SYNC_ERR_TOL_EN and MAX_BIT_ERR=1:
  - Locked, header 47,1C → hdr_ok=1, stays LOCK.
  - 47,1C presented in SEARCH → no acquisition.
  - Without the macro, the same locked stimulus → HOLD.
